// File: rtl/eq_gain_mixer.sv
// Equalizer band weighting/summing stage: per-frame signed gain MAC over all bands of each
// channel, round/saturate to OUT_W, with per-frame gain slewing, bypass and overrun flag.
//  state     | meaning
//  S_IDLE    | waiting for data_en & run
//  S_CAPTURE | frame data/gains held, bypass sampled, MAC counters loaded
//  S_MAC     | one product per cycle, ch-major / band-minor
//  S_FLUSH1  | last product accumulates into its channel sum
//  S_FLUSH2  | round/saturate channel sums into data_out
//  S_RAMP    | out_valid pulse, active gains slew toward targets
module eq_gain_mixer #(
    parameter int NUM_BANDS = 4,
    parameter int NUM_CH    = 2,
    parameter int DATA_W    = 48,
    parameter int GAIN_W    = 16,
    parameter int OUT_W     = 24,
    parameter int OUT_SHIFT = 38,
    parameter int RAMP_STEP = 64
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                run,
    input  logic                                bypass,
    input  logic                                gain_wr,
    input  logic                                gain_wr_rst,
    input  logic [GAIN_W-1:0]                   gain_wr_data,
    output logic                                wr_addr_zero,
    input  logic [$clog2(NUM_BANDS)-1:0]        gain_rd_sel,
    output logic [GAIN_W-1:0]                   gain_rd_data,
    input  logic                                data_en,
    input  logic [NUM_CH*NUM_BANDS*DATA_W-1:0]  data_in,
    output logic [NUM_CH*OUT_W-1:0]             data_out,
    output logic                                out_valid,
    output logic                                busy,
    output logic                                ramping,
    output logic                                sat,
    output logic                                overrun,
    input  logic                                ovr_clr
);
    localparam int N         = NUM_CH * NUM_BANDS;
    localparam int BW        = $clog2(NUM_BANDS);
    localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IW        = (N > 1) ? $clog2(N) : 1;
    localparam int PROD_W    = DATA_W + GAIN_W;
    localparam int ACC_W     = PROD_W + BW;
    localparam int BYP_SHIFT = OUT_SHIFT - GAIN_W + 2;
    localparam logic [BW-1:0]           BMAX = BW'(NUM_BANDS - 1);
    localparam logic [CW-1:0]           CMAX = CW'(NUM_CH - 1);
    localparam logic signed [ACC_W:0]   OMAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0]   OMIN = ~OMAX;
    localparam logic signed [ACC_W:0]   RND  = (ACC_W+1)'(1) << (OUT_SHIFT - 1);
    localparam logic signed [GAIN_W:0]  STEP = (GAIN_W+1)'(RAMP_STEP);

    typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_MAC, S_FLUSH1, S_FLUSH2, S_RAMP} state_t;
    state_t state, state_nx;

    logic        [BW-1:0]      wr_addr;
    logic signed [GAIN_W-1:0]  target    [NUM_BANDS];
    logic signed [GAIN_W-1:0]  active    [NUM_BANDS];
    logic signed [GAIN_W-1:0]  active_nx [NUM_BANDS];
    logic signed [GAIN_W-1:0]  snap_gain [NUM_BANDS];
    logic signed [DATA_W-1:0]  samples   [N];
    logic signed [ACC_W-1:0]   ch_sum    [NUM_CH];
    logic        [BW-1:0]      band_cnt, prod_band;
    logic        [CW-1:0]      ch_cnt, prod_ch;
    logic        [IW-1:0]      mac_idx, mac_left;
    logic        [PROD_W-1:0]  prod_q, mac_s, mac_g;
    logic                      prod_valid, bypass_q;
    logic        [ACC_W-1:0]   acc, acc_base, prod_ext, acc_sum;
    logic [NUM_CH*OUT_W-1:0]   out_nx;
    logic                      clip_any;

    assign busy         = (state != S_IDLE);
    assign wr_addr_zero = (wr_addr == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (data_en) state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = S_MAC;
            S_MAC:     if (mac_left == '0) state_nx = S_FLUSH1;
            S_FLUSH1:  state_nx = S_FLUSH2;
            S_FLUSH2:  state_nx = S_RAMP;
            default:   state_nx = S_IDLE;
        endcase
        if (!run) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_addr <= '0;
            for (int b = 0; b < NUM_BANDS; b++) target[b] <= '0;
        end else if (gain_wr_rst) begin
            wr_addr <= '0;
        end else if (gain_wr) begin
            target[wr_addr] <= gain_wr_data;
            wr_addr         <= (wr_addr == BMAX) ? '0 : wr_addr + 1'b1;
        end
    end

    // Each band independently steps toward its target, snapping once within one step.
    always_comb begin
        logic signed [GAIN_W:0] diff;
        diff     = '0;
        ramping  = 1'b0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            diff = {target[b][GAIN_W-1], target[b]} - {active[b][GAIN_W-1], active[b]};
            if (RAMP_STEP == 0 || (diff <= STEP && diff >= -STEP)) active_nx[b] = target[b];
            else if (diff > 0) active_nx[b] = active[b] + GAIN_W'(RAMP_STEP);
            else               active_nx[b] = active[b] - GAIN_W'(RAMP_STEP);
            if (active[b] != target[b]) ramping = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BANDS; b++) active[b] <= '0;
            gain_rd_data <= '0;
        end else begin
            if (state == S_RAMP && run) active <= active_nx;
            gain_rd_data <= (32'(gain_rd_sel) < NUM_BANDS) ? active[gain_rd_sel] : '0;
        end
    end

    assign mac_s = {{GAIN_W{samples[mac_idx][DATA_W-1]}}, samples[mac_idx]};
    assign mac_g = {{DATA_W{snap_gain[band_cnt][GAIN_W-1]}}, snap_gain[band_cnt]};

    assign acc_base = (prod_band == '0) ? '0 : acc;
    assign prod_ext = {{BW{prod_q[PROD_W-1]}}, prod_q};
    assign acc_sum  = acc_base + prod_ext;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) samples[i] <= '0;
            for (int b = 0; b < NUM_BANDS; b++) snap_gain[b] <= '0;
            for (int c = 0; c < NUM_CH; c++) ch_sum[c] <= '0;
            bypass_q   <= 1'b0;
            band_cnt   <= '0;
            ch_cnt     <= '0;
            mac_idx    <= '0;
            mac_left   <= '0;
            prod_q     <= '0;
            prod_band  <= '0;
            prod_ch    <= '0;
            prod_valid <= 1'b0;
            acc        <= '0;
        end else begin
            if (state == S_IDLE && run && data_en) begin
                for (int i = 0; i < N; i++) samples[i] <= data_in[i*DATA_W +: DATA_W];
                snap_gain <= active;
            end
            if (state == S_CAPTURE) begin
                bypass_q <= bypass;
                band_cnt <= '0;
                ch_cnt   <= '0;
                mac_idx  <= '0;
                mac_left <= IW'(N - 1);
            end
            if (state == S_MAC) begin
                prod_q    <= mac_s * mac_g;
                prod_band <= band_cnt;
                prod_ch   <= ch_cnt;
                mac_idx   <= mac_idx + 1'b1;
                mac_left  <= mac_left - 1'b1;
                if (band_cnt == BMAX) begin
                    band_cnt <= '0;
                    ch_cnt   <= (ch_cnt == CMAX) ? '0 : ch_cnt + 1'b1;
                end else begin
                    band_cnt <= band_cnt + 1'b1;
                end
            end
            prod_valid <= (state == S_MAC) && run;
            if (prod_valid) begin
                acc <= acc_sum;
                if (prod_band == BMAX) ch_sum[prod_ch] <= acc_sum;
            end
        end
    end

    always_comb begin
        logic signed [ACC_W:0] ext_s, ext_b, wide;
        out_nx   = '0;
        clip_any = 1'b0;
        ext_s    = '0;
        ext_b    = '0;
        wide     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ext_s = {ch_sum[c][ACC_W-1], ch_sum[c]};
            ext_b = {{(ACC_W+1-DATA_W){samples[c*NUM_BANDS][DATA_W-1]}}, samples[c*NUM_BANDS]};
            wide  = bypass_q ? (ext_b >>> BYP_SHIFT) : ((ext_s + RND) >>> OUT_SHIFT);
            if (wide > OMAX) begin
                out_nx[c*OUT_W +: OUT_W] = OMAX[OUT_W-1:0];
                clip_any = 1'b1;
            end else if (wide < OMIN) begin
                out_nx[c*OUT_W +: OUT_W] = OMIN[OUT_W-1:0];
                clip_any = 1'b1;
            end else begin
                out_nx[c*OUT_W +: OUT_W] = wide[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            sat       <= 1'b0;
            if (state == S_FLUSH2 && run) begin
                data_out  <= out_nx;
                out_valid <= 1'b1;
                sat       <= clip_any;
            end
            if (data_en && busy) overrun <= 1'b1;
            else if (ovr_clr)    overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_eq_gain_mixer.sv
// Self-checking bench for eq_gain_mixer: randomized frames against a plain-arithmetic model
// of the gain table, slewing, MAC/rounding/saturation, bypass, overrun and abort behaviour.
module tb_eq_gain_mixer;
    localparam int NB = 4, NC = 2, DW = 48, GW = 16, OW = 24, OS = 38, RS = 64;

    logic clk = 1'b0, reset_n = 1'b0, run = 1'b0, bypass = 1'b0;
    logic gain_wr = 1'b0, gain_wr_rst = 1'b0, data_en = 1'b0, ovr_clr = 1'b0;
    logic [GW-1:0] gain_wr_data = '0;
    logic [1:0] gain_rd_sel = '0;
    logic [GW-1:0] gain_rd_data;
    logic [NC*NB*DW-1:0] data_in = '0;
    logic [NC*OW-1:0] data_out;
    logic wr_addr_zero, out_valid, busy, ramping, sat, overrun;

    eq_gain_mixer dut (
        .clk(clk), .reset_n(reset_n), .run(run), .bypass(bypass),
        .gain_wr(gain_wr), .gain_wr_rst(gain_wr_rst), .gain_wr_data(gain_wr_data),
        .wr_addr_zero(wr_addr_zero), .gain_rd_sel(gain_rd_sel), .gain_rd_data(gain_rd_data),
        .data_en(data_en), .data_in(data_in), .data_out(data_out), .out_valid(out_valid),
        .busy(busy), .ramping(ramping), .sat(sat), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic signed [DW-1:0] m_data [NC][NB];
    int m_target [NB];
    int m_active [NB];
    int m_wr;
    logic [OW-1:0] m_prev [NC];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int b = 0; b < NB; b++) begin m_target[b] = 0; m_active[b] = 0; end
        m_wr = 0;
        for (int c = 0; c < NC; c++) m_prev[c] = '0;
    endtask

    function automatic bit m_ramping();
        for (int b = 0; b < NB; b++) if (m_active[b] != m_target[b]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_ramp();
        for (int b = 0; b < NB; b++) begin
            int d;
            d = m_target[b] - m_active[b];
            if (RS == 0 || (d <= RS && d >= -RS)) m_active[b] = m_target[b];
            else if (d > 0) m_active[b] = m_active[b] + RS;
            else            m_active[b] = m_active[b] - RS;
        end
    endtask

    function automatic logic [OW-1:0] m_out(input int c, input bit byp, output bit clip);
        logic signed [127:0] acc, v, mx, mn;
        mx = (128'sd1 <<< (OW-1)) - 128'sd1;
        mn = -mx - 128'sd1;
        if (byp) begin
            v = 128'(m_data[c][0]) >>> (OS - GW + 2);
        end else begin
            acc = '0;
            for (int b = 0; b < NB; b++) acc = acc + 128'(m_data[c][b]) * 128'(m_active[b]);
            v = (acc + (128'sd1 <<< (OS-1))) >>> OS;
        end
        clip = (v > mx) || (v < mn);
        if (v > mx) v = mx;
        if (v < mn) v = mn;
        return v[OW-1:0];
    endfunction

    task automatic pack();
        for (int c = 0; c < NC; c++)
            for (int b = 0; b < NB; b++) data_in[(c*NB+b)*DW +: DW] = m_data[c][b];
    endtask

    task automatic load_rand();
        logic [63:0] r;
        for (int c = 0; c < NC; c++)
            for (int b = 0; b < NB; b++) begin
                r = {$urandom(), $urandom()};
                m_data[c][b] = $signed(r[DW-1:0]) >>> $urandom_range(0, 28);
            end
        pack();
    endtask

    task automatic load_const(input logic signed [DW-1:0] v);
        for (int c = 0; c < NC; c++)
            for (int b = 0; b < NB; b++) m_data[c][b] = v;
        pack();
    endtask

    task automatic wr_gain(input int val, input bit rst_too);
        gain_wr = 1'b1; gain_wr_data = GW'(val); gain_wr_rst = rst_too;
        step();
        gain_wr = 1'b0; gain_wr_rst = 1'b0;
        if (rst_too) m_wr = 0;
        else begin m_target[m_wr] = val; m_wr = (m_wr + 1) % NB; end
        chk("wr_addr_zero", 64'(wr_addr_zero), 64'(m_wr == 0));
        chk("ramping_after_wr", 64'(ramping), 64'(m_ramping()));
    endtask

    task automatic frame(input int ovr_at, input bit ovr_clr_too, input int abort_at, input bit byp);
        int cnt, r;
        bit seen, clip, any_clip;
        logic [OW-1:0] e;
        bypass = byp;
        data_en = 1'b1;
        step();
        data_en = 1'b0;
        cnt = 1;
        if (abort_at > 0) begin
            repeat (abort_at - 1) step();
            run = 1'b0;
            step();
            chk("abort_busy", 64'(busy), 64'd0);
            run = 1'b1;
            seen = 1'b0;
            repeat (20) begin step(); if (out_valid === 1'b1) seen = 1'b1; end
            chk("abort_no_valid", 64'(seen), 64'd0);
            for (int c = 0; c < NC; c++) chk("abort_held", 64'(data_out[c*OW +: OW]), 64'(m_prev[c]));
            return;
        end
        while (out_valid !== 1'b1 && cnt < 40) begin
            if (cnt == ovr_at) begin
                data_en = 1'b1; ovr_clr = ovr_clr_too; data_in = ~data_in;
            end
            step();
            data_en = 1'b0; ovr_clr = 1'b0;
            cnt++;
        end
        chk("latency", 64'(cnt), 64'(NB*NC + 4));
        chk("busy_at_valid", 64'(busy), 64'd1);
        chk("overrun", 64'(overrun), 64'(ovr_at > 0));
        any_clip = 1'b0;
        for (int c = 0; c < NC; c++) begin
            e = m_out(c, byp, clip);
            any_clip |= clip;
            chk("data_out", 64'(data_out[c*OW +: OW]), 64'(e));
            m_prev[c] = e;
        end
        chk("sat", 64'(sat), 64'(any_clip));
        m_ramp();
        step();
        chk("valid_pulse", 64'(out_valid), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("ramping", 64'(ramping), 64'(m_ramping()));
        r = $urandom_range(0, NB-1);
        gain_rd_sel = 2'(r);
        step();
        chk("gain_rd", 64'(gain_rd_data), 64'(GW'(m_active[r])));
    endtask

    initial begin
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ramping", 64'(ramping), 64'd0);
        chk("rst_sat", 64'(sat), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_wr_addr_zero", 64'(wr_addr_zero), 64'd1);
        chk("rst_gain_rd", 64'(gain_rd_data), 64'd0);
        reset_n = 1'b1; run = 1'b1;
        step();

        // Unity targets from zero: 256 frames of +64 slewing.
        for (int b = 0; b < NB; b++) wr_gain(32'h4000, 1'b0);
        for (int k = 0; k < 256; k++) begin load_rand(); frame(0, 1'b0, 0, 1'b0); end
        chk("ramp_done", 64'(ramping), 64'd0);
        gain_rd_sel = 2'd1; step();
        chk("unity_active", 64'(gain_rd_data), 64'h4000);

        // 4 bands of 2^36 at unity: 2^52 >>> 38 = 0x4000.
        load_const(48'sh0010_0000_0000);
        frame(0, 1'b0, 0, 1'b0);
        chk("t1_ch0", 64'(data_out[OW-1:0]), 64'h004000);
        chk("t1_ch1", 64'(data_out[2*OW-1:OW]), 64'h004000);

        load_const(48'sh7FFF_FFFF_FFFF);
        frame(0, 1'b0, 0, 1'b0);
        chk("sat_pos", 64'(data_out), 64'h7FFFFF_7FFFFF);
        load_const(48'sh8000_0000_0000);
        frame(0, 1'b0, 0, 1'b0);
        chk("sat_neg", 64'(data_out), 64'h800000_800000);

        // Address clear wins over a same-cycle write; fifth write wraps to band 0.
        wr_gain(32'h1234, 1'b1);
        for (int i = 0; i < 5; i++) wr_gain(int'($urandom_range(0, 32'h6000)) - 32'h2000, 1'b0);

        load_rand();
        for (int c = 0; c < NC; c++) m_data[c][0] = 48'sh0000_0500_0000;
        pack();
        frame(0, 1'b0, 0, 1'b1);
        chk("bypass_ch0", 64'(data_out[OW-1:0]), 64'h000005);
        chk("bypass_ch1", 64'(data_out[2*OW-1:OW]), 64'h000005);
        for (int k = 0; k < 3; k++) begin load_rand(); frame(0, 1'b0, 0, 1'b1); end
        bypass = 1'b0;

        for (int k = 0; k < 150; k++) begin
            if (k % 50 == 25) wr_gain(int'($urandom_range(0, 32'h8000)) - 32'h4000, 1'b0);
            load_rand();
            frame(0, 1'b0, 0, ($urandom_range(0, 7) == 0));
        end
        bypass = 1'b0;

        load_rand(); frame(5, 1'b0, 0, 1'b0);
        chk("ovr_sticky", 64'(overrun), 64'd1);
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        chk("ovr_cleared", 64'(overrun), 64'd0);
        load_rand(); frame(5, 1'b1, 0, 1'b0);
        chk("ovr_set_wins", 64'(overrun), 64'd1);
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        chk("ovr_cleared2", 64'(overrun), 64'd0);

        load_rand(); frame(0, 1'b0, 4, 1'b0);
        load_rand(); frame(0, 1'b0, 0, 1'b0);

        // Asynchronous reset in the middle of a frame with overrun and ramping pending.
        wr_gain(int'(m_active[m_wr]) + 32'h0100, 1'b0);
        load_rand();
        data_en = 1'b1; step(); data_en = 1'b0;
        step(); data_en = 1'b1; step(); data_en = 1'b0;
        repeat (3) step();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_data_out", 64'(data_out), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_ramping", 64'(ramping), 64'd0);
        chk("arst_overrun", 64'(overrun), 64'd0);
        chk("arst_gain_rd", 64'(gain_rd_data), 64'd0);
        chk("arst_wr_addr_zero", 64'(wr_addr_zero), 64'd1);
        step();
        reset_n = 1'b1;
        m_reset();
        step();
        load_rand(); frame(0, 1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
